branch_predict_unit: RTL
========================

Name: branch_predict_unit

Overview:
- Parametrised successor to the single-cycle branch comparator, for the pipelined core.
- Resolves all branch types at XLEN width.
- Adds a direct-mapped table of 2-bit saturating counters (BHT) for fetch-stage prediction.
- Registers outcome and mispredict to the next cycle and keeps saturating statistics counters.

Parameters:
XLEN, 32, operand and PC width
BHT_ENTRIES, 16, number of counter entries; power of two, >= 2
STAT_W, 32, width of statistics counters

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
lookup_pc  in  XLEN  fetch-stage PC for prediction
lookup_taken  out  1  prediction for lookup_pc; combinational read of table
res_valid  in  1  resolve-stage branch present this cycle
res_pc  in  XLEN  PC of resolving branch
rdata1  in  XLEN  operand 1
rdata2  in  XLEN  operand 2
br_type  in  3  package encoding: BEQ, BNE, BLT, BGE, BLTU, BGEU, PC, ALU
pred_taken  in  1  prediction carried down the pipe with this branch
flush  in  1  kill the resolving branch this cycle
out_valid  out  1  registered: a resolved result is presented
br_taken  out  1  registered actual outcome
mispredict  out  1  registered: out_valid and br_taken != pred_taken
n_branch  out  STAT_W  count of resolved conditional branches
n_mispredict  out  STAT_W  count of conditional mispredicts

Behaviour:
- Reset (async, rst_n=0):
  - out_valid, br_taken, mispredict = 0.
  - n_branch, n_mispredict = 0.
  - All BHT counters = 2'b01 (weakly not-taken).
  - Release is sampled on the next clk edge.
- Index: idx = pc[log2(BHT_ENTRIES)+1 : 2]; bits [1:0] are ignored.
- Prediction: lookup_taken = BHT[idx(lookup_pc)][1]. Purely combinational, no bypass. A same-cycle update to the same index is visible only from the next cycle.
- Compare, combinational within the resolve cycle:
  - BEQ: rdata1 == rdata2. BNE: rdata1 != rdata2.
  - BLT / BGE: signed < / >=.
  - BLTU / BGEU: unsigned < / >=.
  - PC: 0. ALU: 1.
- Conditional types = BEQ..BGEU. PC and ALU are unconditional.
- Accept condition: acc = res_valid & ~flush.
- Output register, updated every edge:
  - out_valid <= acc.
  - br_taken <= acc ? actual : 0.
  - mispredict <= acc & (actual != pred_taken).
  - Latency is 1 cycle. Outputs hold for exactly one cycle; there is no backpressure.
- Mispredict applies to all types, including ALU and PC, since the frontend may mispredict a jump.
- BHT update, on acc with a conditional type only:
  - taken: counter increments, saturating at 2'b11.
  - not-taken: counter decrements, saturating at 2'b00.
  - PC/ALU types never modify the table.
- Statistics, on acc with a conditional type:
  - n_branch increments; saturates at all-ones with no wrap.
  - n_mispredict increments when the same conditional branch mispredicts; same saturation.
- Flush: flush=1 with res_valid=1 means no table update, no stats change, and out_valid=0 next cycle. Flush with res_valid=0 has no effect.
- Undefined br_type values: treat as PC (not taken, no update).
- Reset asserted mid-operation clears all state immediately, independent of clk.

Test Plan:
- Reset table, BEQ rdata1=5, rdata2=5, pred_taken=0, res_pc=0x40 -> next cycle: out_valid=1, br_taken=1, mispredict=1; BHT[0] becomes 2'b10; n_branch=1, n_mispredict=1.
- BLT rdata1=0xFFFFFFFF, rdata2=1 -> taken. BLTU same operands -> not taken. BGEU 0x80000000 vs 0x7FFFFFFF -> taken. Checks the signed/unsigned split at XLEN=32.
- Four taken BNE at pc 0x44 -> counter 01→10→11→11 (saturates); lookup_pc=0x44 gives lookup_taken=1. Three not-taken -> 11→10→01→00 (saturates); lookup_taken=0.
- Aliasing: pc 0x08 and 0x48 with BHT_ENTRIES=16 share index 2. Update via 0x48, then lookup 0x08 reflects it.
- Same-cycle update and lookup at index 3: lookup_taken shows the pre-update value; the following cycle shows the new value.
- Flush: res_valid=1, flush=1, BEQ equal -> out_valid=0, table and stats unchanged.
- ALU type with pred_taken=0 -> br_taken=1, mispredict=1, n_branch unchanged.
- rst_n pulsed low mid-stream -> all outputs and counters are 0 at once; table reads 01 everywhere.

Source files
------------

// File: rtl/branch_predict_unit_if.sv
// Fetch lookup and resolve-stage bundle for branch_predict_unit.
// master: pipeline side (drives PCs/operands); slave: predictor.
interface branch_predict_unit_if #(
  parameter int XLEN   = 32,
  parameter int STAT_W = 32
);
  logic [XLEN-1:0]   lookup_pc;
  logic              lookup_taken;
  logic              res_valid;
  logic [XLEN-1:0]   res_pc;
  logic [XLEN-1:0]   rdata1;
  logic [XLEN-1:0]   rdata2;
  logic [2:0]        br_type;
  logic              pred_taken;
  logic              flush;
  logic              out_valid;
  logic              br_taken;
  logic              mispredict;
  logic [STAT_W-1:0] n_branch;
  logic [STAT_W-1:0] n_mispredict;

  modport master (
    output lookup_pc, res_valid, res_pc,
    output rdata1, rdata2, br_type,
    output pred_taken, flush,
    input  lookup_taken, out_valid,
    input  br_taken, mispredict,
    input  n_branch, n_mispredict
  );

  modport slave (
    input  lookup_pc, res_valid, res_pc,
    input  rdata1, rdata2, br_type,
    input  pred_taken, flush,
    output lookup_taken, out_valid,
    output br_taken, mispredict,
    output n_branch, n_mispredict
  );
endinterface

// File: rtl/branch_predict_unit.sv
// Branch resolver + 2-bit BHT predictor with mispredict stats.
// Ports: clk, rst_n (async low), bp (slave: lookup/resolve/outputs).
module branch_predict_unit #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 16,
  parameter int STAT_W      = 32
) (
  input logic clk,
  input logic rst_n,
  branch_predict_unit_if.slave bp
);
  localparam int IDX_W = $clog2(BHT_ENTRIES);

  localparam logic [2:0] BR_BEQ  = 3'd0;
  localparam logic [2:0] BR_BNE  = 3'd1;
  localparam logic [2:0] BR_BLT  = 3'd2;
  localparam logic [2:0] BR_BGE  = 3'd3;
  localparam logic [2:0] BR_BLTU = 3'd4;
  localparam logic [2:0] BR_BGEU = 3'd5;
  localparam logic [2:0] BR_ALU  = 3'd7;

  logic [1:0]        bht_q [BHT_ENTRIES];
  logic [1:0]        bht_d [BHT_ENTRIES];
  logic              out_valid_q, out_valid_d;
  logic              br_taken_q, br_taken_d;
  logic              mispredict_q, mispredict_d;
  logic [STAT_W-1:0] n_branch_q, n_branch_d;
  logic [STAT_W-1:0] n_mispredict_q, n_mispredict_d;

  logic [IDX_W-1:0]  lk_idx, rs_idx;
  logic              eq, lt_s, lt_u;
  logic              actual, cond, acc, upd, miss;

  logic              unused_pc;
  assign unused_pc = ^{bp.lookup_pc[XLEN-1:IDX_W+2],
                       bp.lookup_pc[1:0],
                       bp.res_pc[XLEN-1:IDX_W+2],
                       bp.res_pc[1:0]};

  assign lk_idx = bp.lookup_pc[IDX_W+1:2];
  assign rs_idx = bp.res_pc[IDX_W+1:2];

  // No bypass: a same-cycle update shows up next cycle.
  assign bp.lookup_taken = bht_q[lk_idx][1];

  assign eq   = bp.rdata1 == bp.rdata2;
  assign lt_s = $signed(bp.rdata1) < $signed(bp.rdata2);
  assign lt_u = bp.rdata1 < bp.rdata2;

  always_comb begin
    actual = 1'b0;
    cond   = 1'b0;
    case (bp.br_type)
      BR_BEQ:  begin actual = eq;    cond = 1'b1; end
      BR_BNE:  begin actual = ~eq;   cond = 1'b1; end
      BR_BLT:  begin actual = lt_s;  cond = 1'b1; end
      BR_BGE:  begin actual = ~lt_s; cond = 1'b1; end
      BR_BLTU: begin actual = lt_u;  cond = 1'b1; end
      BR_BGEU: begin actual = ~lt_u; cond = 1'b1; end
      BR_ALU:  actual = 1'b1;
      default: actual = 1'b0;
    endcase
  end

  assign acc  = bp.res_valid & ~bp.flush;
  assign upd  = acc & cond;
  assign miss = actual != bp.pred_taken;

  always_comb begin
    bht_d = bht_q;
    if (upd) begin
      if (actual && bht_q[rs_idx] != 2'b11)
        bht_d[rs_idx] = bht_q[rs_idx] + 2'd1;
      else if (!actual && bht_q[rs_idx] != 2'b00)
        bht_d[rs_idx] = bht_q[rs_idx] - 2'd1;
    end
  end

  always_comb begin
    out_valid_d    = acc;
    br_taken_d     = acc & actual;
    mispredict_d   = acc & miss;
    n_branch_d     = n_branch_q;
    n_mispredict_d = n_mispredict_q;
    // Stats saturate at all-ones rather than wrap.
    if (upd && n_branch_q != '1)
      n_branch_d = n_branch_q + 1'b1;
    if (upd && miss && n_mispredict_q != '1)
      n_mispredict_d = n_mispredict_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++)
        bht_q[i] <= 2'b01;
      out_valid_q    <= 1'b0;
      br_taken_q     <= 1'b0;
      mispredict_q   <= 1'b0;
      n_branch_q     <= '0;
      n_mispredict_q <= '0;
    end else begin
      bht_q          <= bht_d;
      out_valid_q    <= out_valid_d;
      br_taken_q     <= br_taken_d;
      mispredict_q   <= mispredict_d;
      n_branch_q     <= n_branch_d;
      n_mispredict_q <= n_mispredict_d;
    end
  end

  assign bp.out_valid    = out_valid_q;
  assign bp.br_taken     = br_taken_q;
  assign bp.mispredict   = mispredict_q;
  assign bp.n_branch     = n_branch_q;
  assign bp.n_mispredict = n_mispredict_q;
endmodule
